// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared types and constants for the memory bus responder:
//            FSM state encoding, default bus geometry and wait-state limits.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int MAX_WAIT_STATES    = 3;
    localparam int WAIT_CNT_WIDTH     = $clog2(MAX_WAIT_STATES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Reload value for the wait counter on acceptance. With no wait states
    // the counter is never used, so zero is returned.
    function automatic logic [WAIT_CNT_WIDTH-1:0] wait_init(input int ws);
        if (ws > 0) begin
            return WAIT_CNT_WIDTH'(ws - 1);
        end
        return '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Purpose  : Synchronous single-port word memory with registered read.
//            One operation per cycle when en=1: write if we=1, read if we=0.
//            Storage is not reset; only the read-data register is.
// Ports    : clk, rst        - clock, async active-high reset (rdata only)
//            en, we          - operation strobe and direction
//            addr, wdata     - word address and write data
//            rdata           - registered read data, holds between reads
// Revision : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Array contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Purpose  : Slave side of a simple async-style memory bus (cs/we/oe with a
//            shared tri-state data bus). Requests are accepted in IDLE, wait
//            WAIT_STATES cycles, perform one memory access, then pulse rdy.
//            Illegal requests (we=1 and oe=1) pulse err instead.
// Ports    : clk, rst  - clock, async active-high reset
//            addr      - word address from the initiator
//            data      - shared bidirectional data bus
//            cs/we/oe  - chip select, write enable, output enable (1 = read)
//            rdy       - one-cycle completion pulse
//            err       - one-cycle illegal-request pulse
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    output logic                  rdy,
    output logic                  err
);

    localparam logic [WAIT_CNT_WIDTH-1:0] C_WAIT_INIT = wait_init(WAIT_STATES);

    state_t                    state_q,    state_d;
    logic [WAIT_CNT_WIDTH-1:0] cnt_q,      cnt_d;
    logic [ADDR_WIDTH-1:0]     addr_q,     addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q,    wdata_d;
    logic                      write_q,    write_d;
    logic                      rd_valid_q, rd_valid_d;
    logic                      rdy_q,      rdy_d;
    logic                      err_q,      err_d;

    // rd_q is the registered read port of the array; it updates only on a
    // completed read and therefore holds its value between reads.
    logic [DATA_WIDTH-1:0]     rd_q;
    logic                      mem_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        rd_valid_d = rd_valid_q;
        rdy_d      = 1'b0;
        err_d      = 1'b0;

        // Dropping cs invalidates the last read; a read completing in ACCESS
        // below still takes precedence because that access always finishes.
        if (!cs) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cs) begin
                    if (we ^ oe) begin
                        addr_d     = addr;
                        wdata_d    = data;
                        write_d    = we;
                        rd_valid_d = 1'b0;
                        if (WAIT_STATES > 0) begin
                            state_d = WAIT;
                            cnt_d   = C_WAIT_INIT;
                        end else begin
                            state_d = ACCESS;
                        end
                    end else if (we && oe) begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!cs) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_WIDTH'(1);
                end
            end
            ACCESS: begin
                state_d = DONE;
                if (!write_q) begin
                    rd_valid_d = 1'b1;
                end
            end
            DONE: begin
                // rdy is registered, so it is high in the cycle after DONE,
                // giving WAIT_STATES+2 cycles from the accept edge.
                state_d = IDLE;
                rdy_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            rd_valid_q <= rd_valid_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    // The access is keyed off the current state, so an asynchronous reset
    // during ACCESS removes the strobe before the edge and nothing commits.
    assign mem_en = (state_q == ACCESS);

    mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (write_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rd_q)
    );

    assign data = (cs && oe && !we && rd_valid_q) ? rd_q : {DATA_WIDTH{1'bz}};
    assign rdy  = rdy_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_responder
// Purpose  : Directed self-checking bench. Three responders with 0, 1 and 3
//            wait states share address/control lines; sel picks which one
//            sees cs and whose outputs are observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

    localparam int AW = 12;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic          cs, we, oe;
    logic [DW-1:0] drv;
    logic          drv_en;
    int            sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wire [DW-1:0] bus0, bus1, bus2;
    wire          rdy0, rdy1, rdy2;
    wire          err0, err1, err2;
    wire          cs0 = cs && (sel == 0);
    wire          cs1 = cs && (sel == 1);
    wire          cs2 = cs && (sel == 2);

    assign bus0 = (drv_en && sel == 0) ? drv : {DW{1'bz}};
    assign bus1 = (drv_en && sel == 1) ? drv : {DW{1'bz}};
    assign bus2 = (drv_en && sel == 2) ? drv : {DW{1'bz}};

    mem_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus0),
        .cs(cs0), .we(we), .oe(oe), .rdy(rdy0), .err(err0)
    );
    mem_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus1),
        .cs(cs1), .we(we), .oe(oe), .rdy(rdy1), .err(err1)
    );
    mem_bus_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .addr(addr), .data(bus2),
        .cs(cs2), .we(we), .oe(oe), .rdy(rdy2), .err(err2)
    );

    logic [DW-1:0] bus_m;
    logic          rdy_m, err_m;
    always_comb begin
        bus_m = bus0;
        rdy_m = rdy0;
        err_m = err0;
        case (sel)
            1: begin bus_m = bus1; rdy_m = rdy1; err_m = err1; end
            2: begin bus_m = bus2; rdy_m = rdy2; err_m = err2; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // The bench drives zeros onto the selected bus; if the responder is also
    // driving (its rd_q is nonzero at every call site) the bus will not read 0.
    task automatic check_hiz(input string tag);
        drv    = '0;
        drv_en = 1'b1;
        #1;
        check(tag, 32'(bus_m), 32'h0);
        drv_en = 1'b0;
    endtask

    task automatic start_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cs     = 1'b1;
        addr   = a;
        we     = w;
        oe     = !w;
        drv    = d;
        drv_en = w;
    endtask

    // Issues one transaction, measures cycles from the accept edge to rdy
    // and returns the bus value seen in the rdy cycle.
    task automatic txn(input string tag, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_lat,
                       output logic [DW-1:0] rd);
        int n;
        n  = 0;
        rd = '0;
        start_req(w, a, d);
        if (w) begin
            #1;
            check({tag, "_wrbus"}, 32'(bus_m), 32'(d));
        end
        @(posedge clk);
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (rdy_m) begin
                n  = i;
                rd = bus_m;
                break;
            end
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic go_idle();
        @(negedge clk);
        cs     = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic expect_no_rdy(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (rdy_m) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'h0);
    endtask

    function automatic logic [DW-1:0] fill_val(input int i);
        return 16'h3C00 + 16'(i) * 16'h0107;
    endfunction

    logic [DW-1:0] rd;

    initial begin
        rst = 1'b1; cs = 1'b0; we = 1'b0; oe = 1'b1;
        addr = '0; drv = '0; drv_en = 1'b0; sel = 0;

        // Reset state of every responder
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            sel = u;
            #1;
            check("rst_rdy", 32'(rdy_m), 32'h0);
            check("rst_err", 32'(err_m), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // One wait state: write then read, 3-cycle latency each
        sel = 1;
        txn("ws1_wr", 1'b1, 12'h100, 16'h110C, 3, rd);
        go_idle();
        txn("ws1_rd", 1'b0, 12'h100, 16'h0000, 3, rd);
        check("ws1_rd_data", 32'(rd), 32'h110C);
        go_idle();
        check_hiz("ws1_hiz_cs0");

        // Zero wait states: write then read back-to-back with cs held
        sel = 0;
        txn("ws0_wr", 1'b1, 12'h10B, 16'h0005, 2, rd);
        txn("ws0_rd", 1'b0, 12'h10B, 16'h0000, 2, rd);
        check("ws0_rd_data", 32'(rd), 32'h0005);
        go_idle();

        // Illegal request: err for one cycle, no rdy, memory untouched
        sel = 1;
        txn("ill_pre", 1'b1, 12'h10D, 16'h0D0D, 3, rd);
        go_idle();
        @(negedge clk);
        cs = 1'b1; we = 1'b1; oe = 1'b1; addr = 12'h10D; drv = 16'hDEAD; drv_en = 1'b1;
        @(posedge clk);
        #1;
        check("ill_err_hi", 32'(err_m), 32'h1);
        check("ill_rdy_lo", 32'(rdy_m), 32'h0);
        go_idle();
        we = 1'b0;
        @(posedge clk);
        #1;
        check("ill_err_lo", 32'(err_m), 32'h0);
        expect_no_rdy("ill_no_rdy", 6);
        txn("ill_rd", 1'b0, 12'h10D, 16'h0000, 3, rd);
        check("ill_rd_data", 32'(rd), 32'h0D0D);
        go_idle();

        // Three wait states: abort in WAIT, then reset during ACCESS
        sel = 2;
        txn("ws3_pre", 1'b1, 12'h10F, 16'h1234, 5, rd);
        go_idle();
        start_req(1'b1, 12'h10F, 16'hFFFF);
        @(posedge clk);               // accept -> WAIT
        @(posedge clk);               // second WAIT cycle begins
        go_idle();
        expect_no_rdy("abort_no_rdy", 8);
        txn("abort_rd", 1'b0, 12'h10F, 16'h0000, 5, rd);
        check("abort_rd_data", 32'(rd), 32'h1234);
        go_idle();

        start_req(1'b1, 12'h10F, 16'hFFFF);
        @(posedge clk);               // accept -> WAIT
        repeat (3) @(posedge clk);    // last edge enters ACCESS
        @(negedge clk);
        rst = 1'b1; cs = 1'b0; drv_en = 1'b0; we = 1'b0; oe = 1'b1;
        #1;
        check("rst_acc_rdy", 32'(rdy_m), 32'h0);
        check("rst_acc_err", 32'(err_m), 32'h0);
        @(posedge clk);
        #1;
        check("rst_acc_rdy2", 32'(rdy_m), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        expect_no_rdy("rst_no_rdy", 6);
        txn("rst_rd", 1'b0, 12'h10F, 16'h0000, 5, rd);
        check("rst_rd_data", 32'(rd), 32'h1234);
        go_idle();
        check_hiz("ws3_hiz_cs0");

        // Burst fill and read-back with cs held throughout
        sel = 1;
        for (int i = 0; i < 16; i++) begin
            txn("fill_wr", 1'b1, 12'h100 + 12'(i), fill_val(i), 3, rd);
        end
        for (int i = 0; i < 16; i++) begin
            txn("fill_rd", 1'b0, 12'h100 + 12'(i), 16'h0000, 3, rd);
            check("fill_rd_data", 32'(rd), 32'(fill_val(i)));
            check("fill_rd_nox", 32'($isunknown(rd)), 32'h0);
        end
        go_idle();
        check_hiz("fill_hiz_cs0");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 12, word-address width; depth = 2**ADDR_WIDTH words.
  DATA_WIDTH, 16, word width.
  WAIT_STATES, 1, extra cycles before an access completes; legal range 0..3.
REQ-002 Ports SHALL be, one per line (clock and reset first):
  clk  in  1  single clock; all state changes on the rising edge.
  rst  in  1  reset, asynchronous, active-high.
  addr  in  ADDR_WIDTH  word address from the initiator.
  data  inout  DATA_WIDTH  shared bus; the initiator drives it when oe=0, this block drives it only per REQ-012.
  cs  in  1  chip select, request valid.
  we  in  1  write enable.
  oe  in  1  output enable; 1 means read.
  rdy  out  1  one-cycle completion pulse.
  err  out  1  one-cycle illegal-request pulse.

Function
REQ-003 FSM states SHALL be IDLE, WAIT, ACCESS and DONE.
REQ-004 In IDLE with cs=1 on an edge, the request SHALL be accepted: latch addr into addr_q, data into wdata_q and the operation (write if we=1 and oe=0, read if we=0 and oe=1).
REQ-005 On acceptance, the next state SHALL be WAIT with wait counter = WAIT_STATES-1 if WAIT_STATES>0, else ACCESS.
REQ-006 WAIT SHALL decrement the counter each cycle and go to ACCESS when the counter is 0.
REQ-007 ACCESS SHALL perform exactly one operation: a write stores wdata_q at addr_q; a read loads mem[addr_q] into rd_q and sets rd_valid. The next state SHALL be DONE.
REQ-008 DONE SHALL assert rdy for exactly that cycle and then return to IDLE.
REQ-009 Latency from the accept edge to rdy high SHALL be WAIT_STATES+2 cycles (2 cycles for WAIT_STATES=0).
REQ-010 If cs is held at 1 after DONE, IDLE SHALL accept a new request on the next edge. Repeated identical writes are legal and idempotent.
REQ-011 If cs=1 with we=1 and oe=1 in IDLE, the request SHALL be rejected: err pulses for one cycle, the state stays IDLE and memory is unchanged. cs=1 with we=0 and oe=0 SHALL be ignored without err.
REQ-012 data SHALL be driven with rd_q only while cs=1, oe=1, we=0 and rd_valid=1; it SHALL be hi-Z otherwise.
REQ-013 rd_valid SHALL clear on the next acceptance or whenever cs=0. rd_q SHALL hold its value until the next read completes.
REQ-014 If cs falls in WAIT, the transaction SHALL abort: return to IDLE, no write committed, no rdy.
REQ-015 Once in ACCESS, the operation SHALL complete regardless of cs.
REQ-016 Read-after-write to the same address on back-to-back transactions SHALL return the newly written value.
REQ-017 Memory contents SHALL be uninitialised; no read-before-write guarantee.

Reset
REQ-018 While rst=1, asynchronously: state=IDLE, counter=0, rdy=0, err=0, rd_q=0, rd_valid=0, data hi-Z.
REQ-019 Reset mid-transaction SHALL discard it with no write committed. Memory contents SHALL NOT be reset.

Structure
REQ-020 Package mem_bus_pkg SHALL hold the FSM state enum, the default ADDR_WIDTH/DATA_WIDTH values and MAX_WAIT_STATES=3.
REQ-021 Storage SHALL be a sub-module mem_array: synchronous single-port, one write or one read per cycle, registered read. The FSM and tri-state logic SHALL live in mem_bus_responder.

Verification
REQ-022 WAIT_STATES=1: write 'h110C to 'h100, then read 'h100 -> rdy 3 cycles after each accept edge; data='h110C while oe=1.
REQ-023 WAIT_STATES=0: write 'h0005 to 'h10B, then immediately read 'h10B -> data='h0005; rdy 2 cycles after accept.
REQ-024 cs=1, we=1, oe=1, addr 'h10D -> err pulses for one cycle, no rdy; a subsequent read of 'h10D returns the prior value.
REQ-025 WAIT_STATES=3: write 'hFFFF to 'h10F, drop cs in the second WAIT cycle -> no rdy, memory unchanged; assert rst in a later ACCESS cycle -> IDLE, rdy=0, data hi-Z.
REQ-026 Load 16 words 'h100-'h10F with cs held at 1 throughout, then read all 16 back -> every word matches; each read has oe=1 and each write has oe=0; no bus contention (no X on data).
